// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin scheduler in front of one shared registered
// two's-complement unit (negate / absolute value) with overflow flag.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req_i     per-requester request level (held until done)
//   op_a_i    packed operands, requester i at [i*WIDTH +: WIDTH]
//   mode_i    per-requester operation: 0 = negate, 1 = absolute value
//   gnt_o     one-hot pulse during the cycle the operand is being processed
//   done_o    one-hot pulse during the cycle the result is valid
//   result_o  last computed result, held until the next done
//   ovf_o     operand was the most negative value; held with result_o
//   busy_o    high while an operation is in flight
module comp_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] op_a_i,
  input  logic [N_REQ-1:0]       mode_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [WIDTH-1:0]       result_o,
  output logic                   ovf_o,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Pointer starts at the last requester so requester 0 is scanned first.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [N_REQ-1:0]   mask_q,  mask_d;
  logic [IDX_W-1:0]   win_q,   win_d;
  logic [WIDTH-1:0]   opa_q,   opa_d;
  logic               mode_q,  mode_d;
  logic [N_REQ-1:0]   gnt_q,   gnt_d;
  logic [N_REQ-1:0]   done_q,  done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q,   ovf_d;
  logic               busy_q,  busy_d;

  logic [N_REQ-1:0]   elig_c;
  logic               hit_c;
  logic [IDX_W-1:0]   win_c;
  logic [IDX_W-1:0]   idx_c;
  logic [WIDTH-1:0]   neg_c;
  logic [WIDTH-1:0]   calc_c;

  // Round-robin pick: first eligible requester after the pointer, wrapping.
  always_comb begin
    elig_c = req_i & ~mask_q;
    hit_c  = 1'b0;
    win_c  = ptr_q;
    idx_c  = ptr_q;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx_c = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!hit_c && elig_c[idx_c]) begin
        hit_c = 1'b1;
        win_c = idx_c;
      end
    end
  end

  // Shared datapath on the captured operand; wraps modulo 2^WIDTH.
  assign neg_c  = ~opa_q + WIDTH'(1);
  assign calc_c = (mode_q && !opa_q[WIDTH-1]) ? opa_q : neg_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    // A requester must drop req for a cycle before it becomes eligible again.
    mask_d   = mask_q & req_i;
    win_d    = win_q;
    opa_d    = opa_q;
    mode_d   = mode_q;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (hit_c) begin
          state_d       = S_EXEC;
          ptr_d         = win_c;
          win_d         = win_c;
          opa_d         = op_a_i[32'(win_c)*WIDTH +: WIDTH];
          mode_d        = mode_i[win_c];
          gnt_d[win_c]  = 1'b1;
          mask_d[win_c] = 1'b1;
          busy_d        = 1'b1;
        end
      end
      S_EXEC: begin
        state_d       = S_DONE;
        done_d[win_q] = 1'b1;
        result_d      = calc_c;
        ovf_d         = (opa_q == MIN_NEG);
        busy_d        = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_RST;
      mask_q   <= '0;
      win_q    <= '0;
      opa_q    <= '0;
      mode_q   <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      win_q    <= win_d;
      opa_q    <= opa_d;
      mode_q   <= mode_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_comp_arbiter.sv
// Testbench for comp_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_comp_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] op_a;
  logic [3:0]  mode;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] result;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Observation log filled by the observe helper.
  logic [3:0]  g_log [16];
  int          g_cyc [16];
  logic [3:0]  d_log [16];
  int          d_cyc [16];
  logic [15:0] r_log [16];
  logic        o_log [16];
  int          g_n, d_n, busy_n, both_n;
  logic [3:0]  hold_mask;

  comp_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .op_a_i   (op_a),
    .mode_i   (mode),
    .gnt_o    (gnt),
    .done_o   (done),
    .result_o (result),
    .ovf_o    (ovf),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Holds reset for two edges with all inputs idle; returns just after an edge.
  task automatic do_reset();
    rst_n = 1'b0; req = '0; op_a = '0; mode = '0; hold_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs ncyc cycles, logging grants/dones; a requester drops req one
  // cycle after its done unless its hold_mask bit is set.
  task automatic observe(input int ncyc);
    logic [3:0] drop;
    g_n = 0; d_n = 0; busy_n = 0; both_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      drop = '0;
      if (busy) busy_n++;
      if (gnt != 4'd0 && done != 4'd0) both_n++;
      if (gnt != 4'd0 && g_n < 16) begin
        g_log[g_n] = gnt; g_cyc[g_n] = c; g_n++;
      end
      if (done != 4'd0 && d_n < 16) begin
        d_log[d_n] = done; d_cyc[d_n] = c; r_log[d_n] = result; o_log[d_n] = ovf; d_n++;
        drop = done & ~hold_mask;
      end
      @(posedge clk);
      #1 req = req & ~drop;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; op_a = '0; mode = '0; hold_mask = '0;
    #1;
    checks++; if ({gnt, done, ovf, busy} !== 10'd0) begin errors++; $display("FAIL reset_flags got %b exp 0", {gnt, done, ovf, busy}); end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({gnt, done, ovf, busy} !== 10'd0 || result !== 16'd0) begin errors++; $display("FAIL reset_idle got %b/%h exp 0", {gnt, done, ovf, busy}, result); end
  endtask

  task automatic test_single();
    do_reset();
    op_a[15:0] = 16'h0005; mode[0] = 1'b0; req[0] = 1'b1;
    observe(6);
    checks++; if (g_n !== 1 || g_log[0] !== 4'b0001 || g_cyc[0] !== 1) begin errors++; $display("FAIL single_gnt got n=%0d %b @%0d exp 1 0001 @1", g_n, g_log[0], g_cyc[0]); end
    checks++; if (d_n !== 1 || d_log[0] !== 4'b0001 || d_cyc[0] !== 2) begin errors++; $display("FAIL single_done got n=%0d %b @%0d exp 1 0001 @2", d_n, d_log[0], d_cyc[0]); end
    checks++; if (r_log[0] !== 16'hFFFB || o_log[0] !== 1'b0) begin errors++; $display("FAIL single_result got %h/%b exp fffb/0", r_log[0], o_log[0]); end
    checks++; if (busy_n !== 2) begin errors++; $display("FAIL single_busy got %0d exp 2", busy_n); end
    repeat (3) @(negedge clk);
    checks++; if (result !== 16'hFFFB) begin errors++; $display("FAIL single_hold got %h exp fffb", result); end
  endtask

  task automatic test_abs();
    logic [15:0] ops [2];
    logic [15:0] exp_r [2];
    ops[0] = 16'hFFF0; exp_r[0] = 16'h0010;
    ops[1] = 16'h1234; exp_r[1] = 16'h1234;
    for (int t = 0; t < 2; t++) begin
      op_a[47:32] = ops[t]; mode[2] = 1'b1; req[2] = 1'b1;
      observe(6);
      checks++; if (d_n !== 1 || d_log[0] !== 4'b0100 || r_log[0] !== exp_r[t] || o_log[0] !== 1'b0) begin
        errors++; $display("FAIL abs_%0d got n=%0d %b %h/%b exp 1 0100 %h/0", t, d_n, d_log[0], r_log[0], o_log[0], exp_r[t]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] ops [4];
    logic        mds [4];
    logic [15:0] exp_r [4];
    logic        exp_o [4];
    ops[0] = 16'h8000; mds[0] = 1'b0; exp_r[0] = 16'h8000; exp_o[0] = 1'b1;
    ops[1] = 16'h8000; mds[1] = 1'b1; exp_r[1] = 16'h8000; exp_o[1] = 1'b1;
    ops[2] = 16'h0000; mds[2] = 1'b0; exp_r[2] = 16'h0000; exp_o[2] = 1'b0;
    ops[3] = 16'hFFFF; mds[3] = 1'b0; exp_r[3] = 16'h0001; exp_o[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      op_a[31:16] = ops[t]; mode[1] = mds[t]; req[1] = 1'b1;
      observe(6);
      checks++; if (d_n !== 1 || r_log[0] !== exp_r[t] || o_log[0] !== exp_o[t]) begin
        errors++; $display("FAIL boundary_%0d got n=%0d %h/%b exp 1 %h/%b", t, d_n, r_log[0], o_log[0], exp_r[t], exp_o[t]);
      end
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_r [4];
    do_reset();
    op_a = {16'h0042, 16'h7FFF, 16'h8001, 16'h0100};
    mode = 4'b1010;
    exp_r[0] = 16'hFF00; exp_r[1] = 16'h7FFF; exp_r[2] = 16'h8001; exp_r[3] = 16'h0042;
    req = 4'b1111;
    observe(15);
    checks++; if (g_n !== 4 || d_n !== 4) begin errors++; $display("FAIL contention_count got g=%0d d=%0d exp 4 4", g_n, d_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g_log[i] !== 4'(1 << i) || d_log[i] !== 4'(1 << i) || d_cyc[i] !== 2 + 3 * i || r_log[i] !== exp_r[i]) begin
        errors++; $display("FAIL contention_%0d got g=%b d=%b @%0d r=%h exp %b @%0d r=%h", i, g_log[i], d_log[i], d_cyc[i], r_log[i], 4'(1 << i), 2 + 3 * i, exp_r[i]);
      end
    end
    checks++; if (both_n !== 0) begin errors++; $display("FAIL contention_overlap got %0d exp 0", both_n); end
  endtask

  task automatic test_fairness();
    do_reset();
    op_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    mode = 4'b0000;
    req[0] = 1'b1;
    observe(6);
    req = 4'b0111;
    observe(12);
    checks++; if (g_n !== 3 || g_log[0] !== 4'b0010 || g_log[1] !== 4'b0100 || g_log[2] !== 4'b0001) begin
      errors++; $display("FAIL fairness_order got n=%0d %b %b %b exp 3 0010 0100 0001", g_n, g_log[0], g_log[1], g_log[2]);
    end
    checks++; if (r_log[1] !== 16'hFFFD) begin errors++; $display("FAIL fairness_result got %h exp fffd", r_log[1]); end
  endtask

  task automatic test_hold();
    hold_mask = 4'b1000;
    op_a[63:48] = 16'h0007; mode[3] = 1'b0; req[3] = 1'b1;
    observe(15);
    checks++; if (g_n !== 1 || d_n !== 1 || r_log[0] !== 16'hFFF9) begin
      errors++; $display("FAIL hold_once got g=%0d d=%0d r=%h exp 1 1 fff9", g_n, d_n, r_log[0]);
    end
    hold_mask = 4'b0000;
    req[3] = 1'b0;
    @(posedge clk);
    #1 req[3] = 1'b1;
    observe(6);
    checks++; if (g_n !== 1 || g_log[0] !== 4'b1000 || g_cyc[0] !== 1) begin
      errors++; $display("FAIL hold_regrant got n=%0d %b @%0d exp 1 1000 @1", g_n, g_log[0], g_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op_a = {16'h0000, 16'h0022, 16'h0011, 16'h0009};
    mode = 4'b0000;
    req[0] = 1'b1;
    observe(6);
    req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got gnt=%b busy=%b exp 0010 1", gnt, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({gnt, done, ovf, busy} !== 10'd0 || result !== 16'd0) begin
      errors++; $display("FAIL mid_abort got %b/%h exp 0/0000", {gnt, done, ovf, busy}, result);
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    observe(5);
    checks++; if (d_n !== 0 || g_n !== 0) begin errors++; $display("FAIL mid_nodone got d=%0d g=%0d exp 0 0", d_n, g_n); end
    req = 4'b0101;
    observe(9);
    checks++; if (g_n !== 2 || g_log[0] !== 4'b0001 || g_log[1] !== 4'b0100) begin
      errors++; $display("FAIL mid_rearb got n=%0d %b %b exp 2 0001 0100", g_n, g_log[0], g_log[1]);
    end
  endtask

  // Randomized agents checked against a transaction-level model.
  task automatic test_random();
    int          ptr, phase, cur, v, r, pick;
    logic [3:0]  mask, eg, ed;
    logic [15:0] ca, er, val;
    logic        cm, eo, found;
    int          hold [4];
    logic [3:0]  served;
    do_reset();
    ptr = 3; phase = 0; cur = 0; mask = '0; er = '0; eo = 1'b0; ca = '0; cm = 1'b0; served = '0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge clk);
      // Model reacts to the inputs the DUT just sampled.
      eg = '0; ed = '0;
      mask = mask & req;
      if (phase == 1) begin
        ed[cur] = 1'b1;
        v = int'(ca);
        r = (cm && v < 32768) ? v : (65536 - v) % 65536;
        er = 16'(r);
        eo = (v == 32768);
        phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          pick = (ptr + k) % 4;
          if (!found && req[pick] && !mask[pick]) begin
            found = 1'b1;
            cur = pick;
          end
        end
        if (found) begin
          ptr = cur; mask[cur] = 1'b1; eg[cur] = 1'b1;
          ca = op_a[cur*16 +: 16]; cm = mode[cur];
          phase = 1;
        end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ed[i]) begin
          served[i] = 1'b1;
          hold[i] = int'($urandom_range(0, 3));
        end
        if (served[i]) begin
          if (hold[i] == 0) begin
            req[i] = 1'b0; served[i] = 1'b0;
          end else begin
            hold[i]--;
          end
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
              0: val = 16'h8000;
              1: val = 16'h0000;
              2: val = 16'hFFFF;
              default: val = 16'($urandom);
            endcase
            op_a[i*16 +: 16] = val;
            mode[i] = 1'($urandom_range(0, 1));
            req[i] = 1'b1;
          end else begin
            op_a[i*16 +: 16] = 16'($urandom);
          end
        end
      end
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rand_gnt cyc %0d got %b exp %b", cyc, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL rand_done cyc %0d got %b exp %b", cyc, done, ed); end
      checks++; if (busy !== (phase != 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, busy, phase != 0); end
      checks++; if (result !== er) begin errors++; $display("FAIL rand_result cyc %0d got %h exp %h", cyc, result, er); end
      checks++; if (ovf !== eo) begin errors++; $display("FAIL rand_ovf cyc %0d got %b exp %b", cyc, ovf, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_abs();
    test_boundaries();
    test_contention();
    test_fairness();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
